exception_queue: RTL and testbench

//  Multi-channel successor to the single-cycle exception decoder: per channel, classifies

---
 rtl/exception_queue.sv | 149 ++++++++++++++
 tb/tb_exception_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/exception_queue.sv
// Multi-channel exception classifier feeding a DEPTH-entry FIFO drained to the $rstatus writeback port.
// Optional saturating drop counter enabled by defining EXC_DROP_CNT_EN.
module exception_queue #(
  parameter int NUM_CH      = 2,
  parameter int DEPTH       = 4,
  parameter int CODE_W      = 32,
  parameter int RSTATUS_REG = 30,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_CH-1:0]      i_ch_valid,
  input  logic [NUM_CH*32-1:0]   i_ch_ins,
  input  logic [NUM_CH-1:0]      i_ch_error,
  input  logic                   i_flush,
  input  logic                   i_wb_ready,
  output logic                   o_wb_valid,
  output logic [4:0]             o_wb_reg,
  output logic [CODE_W-1:0]      o_wb_data,
  output logic [CNT_W-1:0]       o_pending_cnt,
  output logic                   o_fifo_full,
  output logic                   o_drop_flag,
  output logic [7:0]             o_drop_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW    = CNT_W + 1;

  typedef logic [2:0] code_t;

  function automatic code_t f_decode(input logic [4:0] op, input logic [4:0] aluop);
    code_t code;
    code = 3'd0;
    if (op == 5'b00000) begin
      case (aluop)
        5'b00000: code = 3'd1;
        5'b00001: code = 3'd3;
        5'b00110: code = 3'd4;
        5'b00111: code = 3'd5;
        default:  code = 3'd0;
      endcase
    end else if (op == 5'b00101) begin
      code = 3'd2;
    end
    return code;
  endfunction

  code_t            r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_drop_flag;

  code_t            w_code     [NUM_CH];
  logic [PTR_W-1:0] w_push_idx [NUM_CH];
  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_push;
  logic [SW-1:0]    w_cap;
  logic [SW-1:0]    w_n_push;
  logic [SW-1:0]    w_n_drop;
  logic             w_pop;
  logic             w_unused_ins;

  // Only the op and aluop fields of each instruction word matter here.
  assign w_unused_ins = ^i_ch_ins;

  assign w_pop = (r_cnt != '0) && i_wb_ready;
  assign w_cap = SW'(DEPTH) - SW'(r_cnt) + SW'(w_pop);

  // NOTE: blocking assignments in always_comb let the running push count feed later channels in the same pass.
  always_comb begin
    w_n_push = '0;
    w_n_drop = '0;
    w_push   = '0;
    w_req    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_code[i]     = f_decode(i_ch_ins[32*i+27 +: 5], i_ch_ins[32*i+2 +: 5]);
      w_req[i]      = i_ch_valid[i] && i_ch_error[i] && (w_code[i] != 3'd0);
      w_push_idx[i] = r_wr_ptr + PTR_W'(w_n_push);
      if (w_req[i]) begin
        if (w_n_push < w_cap) begin
          w_push[i] = 1'b1;
          w_n_push  = w_n_push + SW'(1);
        end else begin
          w_n_drop  = w_n_drop + SW'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_drop_flag <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_push);
      r_cnt    <= r_cnt + CNT_W'(w_n_push) - CNT_W'(w_pop);
      if (w_n_drop != '0) begin
        r_drop_flag <= 1'b1;
      end
    end
  end

  // NOTE: storage has no reset; the output is gated by the count so stale entries are never visible.
  always_ff @(posedge i_clk) begin
    if (!i_flush) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_push[i]) begin
          r_mem[w_push_idx[i]] <= w_code[i];
        end
      end
    end
  end

`ifdef EXC_DROP_CNT_EN
  logic [7:0] r_drop_cnt;
  logic [8:0] w_drop_sum;

  assign w_drop_sum = {1'b0, r_drop_cnt} + 9'(w_n_drop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drop_cnt <= 8'd0;
    end else if (!i_flush) begin
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign o_drop_cnt = r_drop_cnt;
`else
  assign o_drop_cnt = 8'd0;
`endif

  assign o_wb_valid    = (r_cnt != '0);
  assign o_wb_data     = o_wb_valid ? CODE_W'(r_mem[r_rd_ptr]) : '0;
  assign o_wb_reg      = 5'(RSTATUS_REG);
  assign o_pending_cnt = r_cnt;
  assign o_fifo_full   = (r_cnt == CNT_W'(DEPTH));
  assign o_drop_flag   = r_drop_flag;

endmodule

// File: tb/tb_exception_queue.sv
// Self-checking bench for exception_queue: directed vector table, async reset, drop saturation,
// and randomized traffic against a queue-based reference model.
module tb_exception_queue;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4;
  localparam int CODE_W = 32;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  localparam logic [31:0] I_ADD  = 32'h0000_0000;
  localparam logic [31:0] I_SUB  = 32'h0000_0004;
  localparam logic [31:0] I_MUL  = 32'h0000_0018;
  localparam logic [31:0] I_DIV  = 32'h0000_001C;
  localparam logic [31:0] I_ADDI = 32'h2800_0000;
  localparam logic [31:0] I_NON  = 32'h4000_0000;
  localparam logic [31:0] I_OPX  = 32'h0000_0008;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_CH-1:0]    ch_valid;
  logic [NUM_CH*32-1:0] ch_ins;
  logic [NUM_CH-1:0]    ch_error;
  logic                 flush;
  logic                 wb_ready;
  logic                 wb_valid;
  logic [4:0]           wb_reg;
  logic [CODE_W-1:0]    wb_data;
  logic [CNT_W-1:0]     pending_cnt;
  logic                 fifo_full;
  logic                 drop_flag;
  logic [7:0]           drop_cnt;

  exception_queue #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .CODE_W(CODE_W), .RSTATUS_REG(30)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ch_valid(ch_valid), .i_ch_ins(ch_ins), .i_ch_error(ch_error),
    .i_flush(flush), .i_wb_ready(wb_ready),
    .o_wb_valid(wb_valid), .o_wb_reg(wb_reg), .o_wb_data(wb_data),
    .o_pending_cnt(pending_cnt), .o_fifo_full(fifo_full),
    .o_drop_flag(drop_flag), .o_drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int q[$];
  bit m_flag;
  int m_dcnt;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  e;
    logic        f;
    logic        r;
    logic        ev;
    int          ed;
    int          ec;
    logic        ef;
    logic        edf;
    int          edc;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int exp_dcnt(input int c);
`ifdef EXC_DROP_CNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  function automatic int ref_code(input logic [31:0] ins);
    int op;
    int aluop;
    op    = int'(ins >> 27);
    aluop = int'((ins >> 2) & 32'h1F);
    if (op == 5) return 2;
    if (op != 0) return 0;
    if (aluop == 0) return 1;
    if (aluop == 1) return 3;
    if (aluop == 6) return 4;
    if (aluop == 7) return 5;
    return 0;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".wb_valid"}, int'(wb_valid), int'(q.size() > 0));
    check({tag, ".wb_data"}, int'(wb_data), (q.size() > 0) ? q[0] : 0);
    check({tag, ".pending_cnt"}, int'(pending_cnt), q.size());
    check({tag, ".fifo_full"}, int'(fifo_full), int'(q.size() == DEPTH));
    check({tag, ".drop_flag"}, int'(drop_flag), int'(m_flag));
    check({tag, ".drop_cnt"}, int'(drop_cnt), exp_dcnt(m_dcnt));
    check({tag, ".wb_reg"}, int'(wb_reg), 30);
  endtask

  task automatic cycle(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [1:0] e, input logic f, input logic r, input string tag);
    int  drops;
    bit  pop;
    ch_valid = v;
    ch_ins   = {a1, a0};
    ch_error = e;
    flush    = f;
    wb_ready = r;
    drops = 0;
    pop   = (q.size() > 0) && r;
    if (f) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      for (int ch = 0; ch < NUM_CH; ch++) begin
        int c;
        c = ref_code(ch == 0 ? a0 : a1);
        if (v[ch] && e[ch] && c != 0) begin
          if (q.size() < DEPTH) q.push_back(c);
          else drops++;
        end
      end
      if (drops > 0) m_flag = 1'b1;
      m_dcnt = (m_dcnt + drops > 255) ? 255 : m_dcnt + drops;
    end
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    logic [31:0] pool [8];
    pool = '{I_ADD, I_SUB, I_MUL, I_DIV, I_ADDI, I_NON, I_OPX, I_ADD};

    tbl[0]  = '{2'b01, I_SUB,  I_ADD,  2'b01, 1'b0, 1'b0, 1'b1, 3, 1, 1'b0, 1'b0, 0};
    tbl[1]  = '{2'b00, I_ADD,  I_ADD,  2'b00, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0};
    tbl[2]  = '{2'b11, I_MUL,  I_ADDI, 2'b11, 1'b0, 1'b1, 1'b1, 4, 2, 1'b0, 1'b0, 0};
    tbl[3]  = '{2'b00, I_ADD,  I_ADD,  2'b00, 1'b0, 1'b1, 1'b1, 2, 1, 1'b0, 1'b0, 0};
    tbl[4]  = '{2'b00, I_ADD,  I_ADD,  2'b00, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0};
    tbl[5]  = '{2'b11, I_NON,  I_ADD,  2'b01, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0};
    tbl[6]  = '{2'b01, I_OPX,  I_ADD,  2'b01, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0};
    tbl[7]  = '{2'b11, I_ADD,  I_DIV,  2'b11, 1'b0, 1'b0, 1'b1, 1, 2, 1'b0, 1'b0, 0};
    tbl[8]  = '{2'b11, I_ADDI, I_SUB,  2'b11, 1'b0, 1'b0, 1'b1, 1, 4, 1'b1, 1'b0, 0};
    tbl[9]  = '{2'b11, I_MUL,  I_MUL,  2'b11, 1'b0, 1'b0, 1'b1, 1, 4, 1'b1, 1'b1, 2};
    tbl[10] = '{2'b11, I_SUB,  I_ADD,  2'b11, 1'b0, 1'b1, 1'b1, 5, 4, 1'b1, 1'b1, 3};
    tbl[11] = '{2'b00, I_ADD,  I_ADD,  2'b00, 1'b0, 1'b1, 1'b1, 2, 3, 1'b0, 1'b1, 3};
    tbl[12] = '{2'b01, I_DIV,  I_ADD,  2'b01, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 3};

    rst_n = 1'b0; ch_valid = '0; ch_ins = '0; ch_error = '0; flush = 1'b0; wb_ready = 1'b0;
    m_flag = 1'b0; m_dcnt = 0;
    #3;
    compare_all("reset0");
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 13; k++) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      cycle(tbl[k].v, tbl[k].i0, tbl[k].i1, tbl[k].e, tbl[k].f, tbl[k].r, tag);
      check({tag, ".tbl_valid"}, int'(wb_valid), int'(tbl[k].ev));
      check({tag, ".tbl_data"}, int'(wb_data), tbl[k].ed);
      check({tag, ".tbl_cnt"}, int'(pending_cnt), tbl[k].ec);
      check({tag, ".tbl_full"}, int'(fifo_full), int'(tbl[k].ef));
      check({tag, ".tbl_dflag"}, int'(drop_flag), int'(tbl[k].edf));
      check({tag, ".tbl_dcnt"}, int'(drop_cnt), exp_dcnt(tbl[k].edc));
    end

    // Asynchronous reset with three entries queued, asserted between clock edges.
    cycle(2'b11, I_ADD, I_SUB, 2'b11, 1'b0, 1'b0, "pre_rst_a");
    cycle(2'b01, I_MUL, I_ADD, 2'b01, 1'b0, 1'b0, "pre_rst_b");
    check("pre_rst.cnt", int'(pending_cnt), 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst.wb_valid", int'(wb_valid), 0);
    check("arst.wb_data", int'(wb_data), 0);
    check("arst.cnt", int'(pending_cnt), 0);
    check("arst.full", int'(fifo_full), 0);
    check("arst.drop_flag", int'(drop_flag), 0);
    check("arst.drop_cnt", int'(drop_cnt), 0);
    check("arst.wb_reg", int'(wb_reg), 30);
    q.delete(); m_flag = 1'b0; m_dcnt = 0;
    #1 rst_n = 1'b1;

    cycle(2'b11, I_ADD, I_SUB, 2'b11, 1'b0, 1'b0, "sat_fill_a");
    cycle(2'b11, I_ADDI, I_DIV, 2'b11, 1'b0, 1'b0, "sat_fill_b");
    for (int k = 0; k < 150; k++) begin
      cycle(2'b11, I_MUL, I_DIV, 2'b11, 1'b0, 1'b0, "sat_drop");
    end
    check("sat.drop_cnt_final", int'(drop_cnt), exp_dcnt(255));
    check("sat.drop_flag_final", int'(drop_flag), 1);
    cycle(2'b00, I_ADD, I_ADD, 2'b00, 1'b1, 1'b0, "sat_flush");
    check("sat.drop_cnt_after_flush", int'(drop_cnt), exp_dcnt(255));

    for (int k = 0; k < 3000; k++) begin
      cycle(2'($urandom), pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)],
            2'($urandom), ($urandom_range(0, 31) == 0), 1'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
